brew_sequencer: RTL
===================

BREW_SEQUENCER -- requirements
Module: brew_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on tick_in.
REQ-002 Parameter TIME_W, default 4: width of the phase countdown and the secs_left output.
REQ-003 clk  input  1: system clock, the same clock that feeds the frequency divider.
REQ-004 clear  input  1: asynchronous, active-low reset.
REQ-005 tick_in  input  1: slow square wave from a divider tap (~6 Hz); treated as asynchronous to clk.
REQ-006 start  input  1: request a brew; sampled on the clk rising edge.
REQ-007 drink_sel  input  2: drink code; 0 = espresso, 1 = coffee, 2 = chocolate, 3 = invalid.
REQ-008 abort  input  1: cancel the brew in progress.
REQ-009 busy  output  1: high in WATER, POWDER and MIX.
REQ-010 valve_water, dose_powder, motor_mix  output  1 each: actuator enables, high only in their own phase.
REQ-011 done  output  1: one-clk pulse on normal completion.
REQ-012 phase  output  2: 0 = IDLE, 1 = WATER, 2 = POWDER, 3 = MIX.
REQ-013 secs_left  output  TIME_W: remaining ticks in the current phase; 0 in IDLE.

Function
REQ-014 tick_in SHALL pass through SYNC_STAGES flops followed by a rising-edge detector, giving a one-clk tick pulse per tick_in period.
REQ-015 The FSM SHALL have states IDLE, WATER, POWDER, MIX and DONE; all outputs SHALL be registered (Moore).
REQ-016 Duration table in ticks (water/powder/mix): espresso 4/2/3; coffee 8/3/4; chocolate 6/5/0.
REQ-017 In IDLE, start=1 with drink_sel<3 SHALL latch drink_sel and move to WATER on the next edge, with secs_left loaded to the water duration.
REQ-018 In IDLE, start=1 with drink_sel=3 SHALL be ignored and the FSM SHALL remain in IDLE.
REQ-019 In any active phase, each tick SHALL decrement secs_left by 1.
REQ-020 A tick while secs_left=1 SHALL advance to the next phase and load that phase's duration.
REQ-021 A phase with duration 0 SHALL be skipped with no cycle spent in it: chocolate goes POWDER -> DONE directly.
REQ-022 Sequence: MIX done -> DONE; DONE SHALL last exactly one clk, assert done, then return to IDLE.
REQ-023 A tick in the same cycle as start or a phase load SHALL NOT be counted.
REQ-024 start while busy, or while in DONE, SHALL be ignored; drink_sel changes while busy SHALL have no effect.
REQ-025 abort=1 in WATER, POWDER, MIX or DONE SHALL force IDLE on the next edge.
REQ-026 On abort, all actuators and secs_left SHALL be 0 and done SHALL NOT pulse.
REQ-027 When abort and start are both high in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-028 secs_left SHALL never wrap below 0; TIME_W SHALL hold the largest table entry (8).

Reset
REQ-029 clear=0 SHALL asynchronously force IDLE, zero all outputs, zero the synchronizer and edge-detector flops, and zero the latched drink code.
REQ-030 After clear is released, the first tick SHALL be detected only on a genuine 0->1 transition of the synchronized tick_in; a tick_in that is already high at release SHALL NOT produce a tick.
REQ-031 clear asserted mid-brew SHALL drop all actuators immediately, without waiting for a clk edge.

Structure
REQ-032 Package brew_pkg SHALL hold the state enumeration, the drink-code constants and the duration table constants.
REQ-033 Sub-module tick_sync SHALL contain the synchronizer and edge detector; brew_sequencer SHALL contain the FSM, the counter and the output registers.

Verification
REQ-034 Scenario 1: drink_sel=0, start pulse, 9 ticks -> WATER for 4 ticks, POWDER for 2, MIX for 3, then a single done pulse and phase=0.
REQ-035 Scenario 2: drink_sel=2, start -> WATER 6, POWDER 5, then done; motor_mix never asserts.
REQ-036 Scenario 3: drink_sel=1, abort after 3 ticks of WATER -> phase=0 next clk, valve_water=0, no done pulse.
REQ-037 Scenario 4: drink_sel=3 with start, and separately start+abort together in IDLE -> busy stays 0.
REQ-038 Scenario 5: clear pulled low mid-POWDER between clk edges -> outputs 0 immediately; after release, tick_in held high produces no tick.
REQ-039 Scenario 6: tick coincident with the start edge -> WATER still lasts the full 4 ticks for espresso; a second start during MIX is ignored.

Source files
------------

// File: rtl/brew_pkg.sv
// Shared definitions for the brew sequencer: FSM state encoding, drink codes,
// per-drink phase durations (in ticks) and helpers that look them up.
package brew_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WATER,
    ST_POWDER,
    ST_MIX,
    ST_DONE
  } state_e;

  localparam logic [1:0] DRINK_ESPRESSO  = 2'd0;
  localparam logic [1:0] DRINK_COFFEE    = 2'd1;
  localparam logic [1:0] DRINK_CHOCOLATE = 2'd2;
  localparam logic [1:0] DRINK_INVALID   = 2'd3;

  localparam int unsigned DUR_ESP_WATER  = 4;
  localparam int unsigned DUR_ESP_POWDER = 2;
  localparam int unsigned DUR_ESP_MIX    = 3;
  localparam int unsigned DUR_COF_WATER  = 8;
  localparam int unsigned DUR_COF_POWDER = 3;
  localparam int unsigned DUR_COF_MIX    = 4;
  localparam int unsigned DUR_CHO_WATER  = 6;
  localparam int unsigned DUR_CHO_POWDER = 5;
  localparam int unsigned DUR_CHO_MIX    = 0;

  // Duration of a phase for a drink; 0 for non-phase states and the invalid code.
  function automatic int unsigned phase_dur(input logic [1:0] drink, input state_e st);
    int unsigned d;
    d = 0;
    unique case (drink)
      DRINK_ESPRESSO:
        d = (st == ST_WATER) ? DUR_ESP_WATER : (st == ST_POWDER) ? DUR_ESP_POWDER :
            (st == ST_MIX) ? DUR_ESP_MIX : 0;
      DRINK_COFFEE:
        d = (st == ST_WATER) ? DUR_COF_WATER : (st == ST_POWDER) ? DUR_COF_POWDER :
            (st == ST_MIX) ? DUR_COF_MIX : 0;
      DRINK_CHOCOLATE:
        d = (st == ST_WATER) ? DUR_CHO_WATER : (st == ST_POWDER) ? DUR_CHO_POWDER :
            (st == ST_MIX) ? DUR_CHO_MIX : 0;
      default: d = 0;
    endcase
    return d;
  endfunction

  // Phase that follows st, skipping any phase whose duration is zero.
  function automatic state_e next_phase(input logic [1:0] drink, input state_e st);
    state_e n;
    n = ST_DONE;
    if (st == ST_WATER) begin
      if (phase_dur(drink, ST_POWDER) != 0)   n = ST_POWDER;
      else if (phase_dur(drink, ST_MIX) != 0) n = ST_MIX;
    end else if (st == ST_POWDER) begin
      if (phase_dur(drink, ST_MIX) != 0)      n = ST_MIX;
    end
    return n;
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Synchronizes the slow tick square wave into the clk domain and emits a
// one-clk pulse per rising edge.
// Ports: i_clk, i_clear_n (async active-low), i_tick_in (async), o_tick (pulse).
module tick_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_clear_n,
  input  logic i_tick_in,
  output logic o_tick
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_vld;
  logic                   r_prev;
  logic                   r_armed;
  logic                   w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // r_vld tracks when the chain holds real samples; edges are only accepted
  // once a genuine low level has been seen, so a level already high at reset
  // release is not mistaken for a rising edge.
  always_ff @(posedge i_clk or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_sync  <= '0;
      r_vld   <= '0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync[0] <= i_tick_in;
      r_vld[0]  <= 1'b1;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
      r_prev <= w_sync_out;
      if (r_vld[SYNC_STAGES-1] && !w_sync_out) r_armed <= 1'b1;
    end
  end

  assign o_tick = r_armed & w_sync_out & ~r_prev;

endmodule

// File: rtl/brew_sequencer.sv
// Drink brewing sequencer: IDLE -> WATER -> POWDER -> MIX -> DONE, each phase
// timed in synchronized ticks. All outputs are registered.
// Ports: clk, clear (async active-low), tick_in (async slow wave), start,
// drink_sel[1:0], abort; outputs busy, valve_water, dose_powder, motor_mix,
// done, phase[1:0], secs_left[TIME_W-1:0].
module brew_sequencer
  import brew_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIME_W      = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              tick_in,
  input  logic              start,
  input  logic [1:0]        drink_sel,
  input  logic              abort,
  output logic              busy,
  output logic              valve_water,
  output logic              dose_powder,
  output logic              motor_mix,
  output logic              done,
  output logic [1:0]        phase,
  output logic [TIME_W-1:0] secs_left
);

  logic              w_tick;
  state_e            r_state, w_next_state;
  logic [TIME_W-1:0] r_secs, w_next_secs;
  logic [1:0]        r_drink, w_next_drink;
  logic              r_busy, r_valve, r_dose, r_motor, r_done;
  logic [1:0]        r_phase;
  logic              w_busy, w_valve, w_dose, w_motor, w_done;
  logic [1:0]        w_phase;

  tick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync (
    .i_clk     (clk),
    .i_clear_n (clear),
    .i_tick_in (tick_in),
    .o_tick    (w_tick)
  );

  // State, counter and output registers; outputs are loaded from the decoded
  // next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= ST_IDLE;
      r_secs  <= '0;
      r_drink <= '0;
      r_busy  <= 1'b0;
      r_valve <= 1'b0;
      r_dose  <= 1'b0;
      r_motor <= 1'b0;
      r_done  <= 1'b0;
      r_phase <= '0;
    end else begin
      r_state <= w_next_state;
      r_secs  <= w_next_secs;
      r_drink <= w_next_drink;
      r_busy  <= w_busy;
      r_valve <= w_valve;
      r_dose  <= w_dose;
      r_motor <= w_motor;
      r_done  <= w_done;
      r_phase <= w_phase;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_secs  = r_secs;
    w_next_drink = r_drink;
    unique case (r_state)
      ST_IDLE: begin
        if (!abort && start && (drink_sel != DRINK_INVALID)) begin
          w_next_state = ST_WATER;
          w_next_drink = drink_sel;
          w_next_secs  = TIME_W'(phase_dur(drink_sel, ST_WATER));
        end
      end
      ST_WATER, ST_POWDER, ST_MIX: begin
        if (abort) begin
          w_next_state = ST_IDLE;
          w_next_secs  = '0;
        end else if (w_tick && (r_secs != '0)) begin
          if (r_secs == TIME_W'(1)) begin
            w_next_state = next_phase(r_drink, r_state);
            w_next_secs  = TIME_W'(phase_dur(r_drink, w_next_state));
          end else begin
            w_next_secs = r_secs - TIME_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
        w_next_secs  = '0;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_secs  = '0;
      end
    endcase
  end

  always_comb begin
    w_busy  = 1'b0;
    w_valve = 1'b0;
    w_dose  = 1'b0;
    w_motor = 1'b0;
    w_done  = 1'b0;
    w_phase = 2'd0;
    unique case (w_next_state)
      ST_WATER:  begin w_busy = 1'b1; w_valve = 1'b1; w_phase = 2'd1; end
      ST_POWDER: begin w_busy = 1'b1; w_dose  = 1'b1; w_phase = 2'd2; end
      ST_MIX:    begin w_busy = 1'b1; w_motor = 1'b1; w_phase = 2'd3; end
      ST_DONE:   w_done = 1'b1;
      default:   w_phase = 2'd0;
    endcase
  end

  assign busy        = r_busy;
  assign valve_water = r_valve;
  assign dose_powder = r_dose;
  assign motor_mix   = r_motor;
  assign done        = r_done;
  assign phase       = r_phase;
  assign secs_left   = r_secs;

endmodule
